// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the writeback stage: result-source selects,
// load funct3 codes, stage FSM states and the latched load context.
package rv32i_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned INSTR_W = 64;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // Everything needed to finish a load whose data arrives late.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic [F3_W-1:0]   funct3;
    logic [OFF_W-1:0]  offset;
  } load_ctx_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: selects byte/halfword by address offset and
// sign- or zero-extends according to funct3.
module wb_load_align
  import rv32i_pkg::*;
(
  input  logic [F3_W-1:0]  funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword accesses ignore offset[0].
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data_c = rdata;
    case (funct3)
      F3_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_c = {24'd0, byte_sel};
      F3_LH:   data_c = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_c = {16'd0, half_sel};
      F3_LW:   data_c = rdata;
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: selects the result source, waits for late load data,
// drives the registered register-file write port and counts retirements.
module wb_stage
  import rv32i_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic                mem_rd_wr_en,
  input  logic [1:0]          mem_wb_sel,
  input  logic [F3_W-1:0]     mem_funct3,
  input  logic [XLEN-1:0]     mem_alu_result,
  input  logic [XLEN-1:0]     mem_pc_plus4,
  input  logic                dmem_rvalid,
  input  logic [XLEN-1:0]     dmem_rdata,
  input  logic                flush,
  output logic [REG_AW-1:0]   rd,
  output logic [XLEN-1:0]     rd_wr_data,
  output logic                rd_wr_en,
  output logic                retire,
  output logic [INSTR_W-1:0]  instret
);

  wb_state_e         state_q, state_d;
  load_ctx_t         ctx_q, ctx_d;
  wb_sel_e           sel;
  logic              done;
  logic [REG_AW-1:0] wr_rd;
  logic              wr_en_raw;
  logic [XLEN-1:0]   wr_data;
  logic [F3_W-1:0]   align_f3;
  logic [OFF_W-1:0]  align_off;
  logic [XLEN-1:0]   load_data;

  assign mem_ready = (state_q == IDLE);
  assign sel       = wb_sel_e'(mem_wb_sel);

  // Same-cycle loads align the live inputs; stalled loads use the latched context.
  assign align_f3  = (state_q == WAIT_LOAD) ? ctx_q.funct3 : mem_funct3;
  assign align_off = (state_q == WAIT_LOAD) ? ctx_q.offset : mem_alu_result[OFF_W-1:0];

  wb_load_align u_align (
    .funct3 (align_f3),
    .offset (align_off),
    .rdata  (dmem_rdata),
    .data_c (load_data)
  );

  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    done      = 1'b0;
    wr_rd     = '0;
    wr_en_raw = 1'b0;
    wr_data   = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && !flush) begin
          if (sel == WB_SEL_LOAD) begin
            if (dmem_rvalid) begin
              done      = 1'b1;
              wr_rd     = mem_rd;
              wr_en_raw = mem_rd_wr_en;
              wr_data   = load_data;
            end else begin
              ctx_d   = '{rd: mem_rd, wr_en: mem_rd_wr_en, funct3: mem_funct3,
                          offset: mem_alu_result[OFF_W-1:0]};
              state_d = WAIT_LOAD;
            end
          end else begin
            done      = 1'b1;
            wr_rd     = mem_rd;
            wr_en_raw = mem_rd_wr_en;
            wr_data   = (sel == WB_SEL_PC4) ? mem_pc_plus4 : mem_alu_result;
          end
        end
      end
      WAIT_LOAD: begin
        // Flush wins over data arriving in the same cycle.
        if (flush) begin
          state_d = IDLE;
          ctx_d   = '0;
        end else if (dmem_rvalid) begin
          done      = 1'b1;
          wr_rd     = ctx_q.rd;
          wr_en_raw = ctx_q.wr_en;
          wr_data   = load_data;
          state_d   = IDLE;
          ctx_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ctx_q      <= '0;
      rd         <= '0;
      rd_wr_data <= '0;
      rd_wr_en   <= 1'b0;
      retire     <= 1'b0;
      instret    <= '0;
    end else begin
      state_q    <= state_d;
      ctx_q      <= ctx_d;
      rd         <= wr_rd;
      rd_wr_data <= wr_data;
      rd_wr_en   <= wr_en_raw && (wr_rd != '0);
      retire     <= done;
      if (done) instret <= instret + INSTR_W'(1);
    end
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL provide: clk  in  1  clock, rising-edge active.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: mem_valid  in  1  memory-stage instruction valid.
REQ-004 SHALL provide: mem_ready  out  1  wb_stage can accept the presented instruction.
REQ-005 SHALL provide: mem_rd  in  5  destination register address.
REQ-006 SHALL provide: mem_rd_wr_en  in  1  instruction writes a register.
REQ-007 SHALL provide: mem_wb_sel  in  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 reserved (treated as ALU).
REQ-008 SHALL provide: mem_funct3  in  3  load type.
REQ-009 SHALL provide: mem_alu_result  in  32  ALU result; for loads, the byte address.
REQ-010 SHALL provide: mem_pc_plus4  in  32  link value.
REQ-011 SHALL provide: dmem_rvalid  in  1  load data valid this cycle.
REQ-012 SHALL provide: dmem_rdata  in  32  raw aligned word from data memory.
REQ-013 SHALL provide: flush  in  1  kill the pending instruction.
REQ-014 SHALL provide: rd  out  5, rd_wr_data  out  32, rd_wr_en  out  1  register-file write port.
REQ-015 SHALL provide: retire  out  1  one instruction retired this cycle.
REQ-016 SHALL provide: instret  out  64  retired-instruction count.

Function
REQ-017 SHALL use FSM states IDLE and WAIT_LOAD; mem_ready = (state == IDLE).
REQ-018 SHALL accept an instruction in IDLE when mem_valid=1 and flush=0.
REQ-019 Non-load accepted at cycle N SHALL produce rd, rd_wr_data and rd_wr_en registered at N+1, held for exactly one cycle.
REQ-020 Load accepted with dmem_rvalid=1 in the same cycle SHALL also complete at N+1.
REQ-021 Load accepted with dmem_rvalid=0 SHALL latch rd, rd_wr_en, funct3 and addr[1:0], then enter WAIT_LOAD.
REQ-022 In WAIT_LOAD, the first cycle with dmem_rvalid=1 SHALL write the aligned data at the next edge and return to IDLE.
REQ-023 Alignment SHALL follow the byte offset o = addr[1:0].
- LB (000) / LBU (100): byte o, sign-extended / zero-extended.
- LH (001) / LHU (101): halfword o[1], sign-extended / zero-extended; o[0] ignored.
- LW (010) and any other funct3: full word.
REQ-024 rd_wr_en SHALL be 1 only when the instruction's rd_wr_en=1 and rd≠0; retire SHALL pulse regardless.
REQ-025 flush in WAIT_LOAD SHALL discard the load with no write and no retire, and return to IDLE next edge.
REQ-026 flush in IDLE SHALL suppress acceptance that cycle.
REQ-027 instret SHALL increment by one on each retire, wrapping from 2^64-1 to 0.
REQ-028 WB_SEL=2 SHALL write mem_pc_plus4; ALU/reserved SHALL write mem_alu_result.
REQ-029 Outputs SHALL be registers only; no combinational path from inputs to rd*, retire or instret.
REQ-030 dmem_rvalid in IDLE with no load accepted SHALL be ignored.

Reset
REQ-031 rst SHALL force state IDLE and clear rd, rd_wr_data, rd_wr_en, retire, instret and all latched load fields.
REQ-032 rst during WAIT_LOAD SHALL abandon the load; a dmem_rvalid arriving after reset SHALL be ignored.

Structure
REQ-033 The WB_SEL encodings and funct3 load constants SHALL reside in the shared package rv32i_pkg.
REQ-034 Load alignment and extension SHALL be a combinational sub-module named wb_load_align.

Verification
REQ-035 ALU op with rd=5 and result 0x1234_5678 -> at N+1: rd=5, rd_wr_data=0x12345678, rd_wr_en=1, retire=1, instret=1.
REQ-036 LB with addr=0x...3, dmem_rdata=0x80FF_FF7F and rvalid in the same cycle -> rd_wr_data=0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
REQ-037 LH with addr[1:0]=2, rvalid 3 cycles late, dmem_rdata=0x8001_0000 -> mem_ready=0 for 3 cycles, then rd_wr_data=0xFFFF_8001 one edge after rvalid.
REQ-038 JAL with rd=0 and pc_plus4=0x104 -> rd_wr_en=0, retire=1, instret increments.
REQ-039 Load stalled in WAIT_LOAD, flush asserted, then rvalid -> no write, no retire, mem_ready=1 the cycle after flush.
REQ-040 rst asserted mid-WAIT_LOAD with instret=7 -> all outputs 0, state IDLE, a later rvalid produces no write.
